// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - 5-stage pipeline sequencer: load-use stall, branch squash, memory freeze, HLT drain
module pipeline_hazard_ctrl #(
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       fd_rs,
    input  logic [3:0]       fd_rt,
    input  logic             fd_uses_rt,
    input  logic             fd_hlt,
    input  logic             de_mem_read,
    input  logic [3:0]       de_write_reg,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             fd_en,
    output logic             de_en,
    output logic             xm_en,
    output logic             mw_en,
    output logic             fd_flush,
    output logic             de_flush,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MEM_WAIT,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic             pend_flush_q, pend_flush_d;
    logic [DW-1:0]    drain_cnt_q, drain_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic load_use;
    logic run_rules;
    logic br_eff;
    logic freeze;
    logic flush_inc;
    logic stall_inc;

    assign load_use = de_mem_read && (de_write_reg != 4'd0) &&
                      ((de_write_reg == fd_rs) ||
                       (fd_uses_rt && (de_write_reg == fd_rt)));

    always_comb begin
        pc_en        = 1'b1;
        fd_en        = 1'b1;
        de_en        = 1'b1;
        xm_en        = 1'b1;
        mw_en        = 1'b1;
        fd_flush     = 1'b0;
        de_flush     = 1'b0;
        halted       = 1'b0;
        state_d      = state_q;
        pend_flush_d = pend_flush_q;
        drain_cnt_d  = drain_cnt_q;
        run_rules    = 1'b0;
        br_eff       = br_taken;
        freeze       = 1'b0;
        flush_inc    = 1'b0;
        stall_inc    = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_rules = 1'b1;
            end
            ST_MEM_WAIT: begin
                if (mem_busy) begin
                    freeze       = 1'b1;
                    pend_flush_d = pend_flush_q | br_taken;
                end else begin
                    // Resume as RUN, replaying any branch that resolved while frozen
                    run_rules    = 1'b1;
                    br_eff       = br_taken | pend_flush_q;
                    pend_flush_d = 1'b0;
                    state_d      = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (mem_busy) begin
                    freeze = 1'b1;
                end else if (br_taken) begin
                    // HLT sat on the wrong path of an older branch
                    fd_flush  = 1'b1;
                    de_flush  = 1'b1;
                    flush_inc = 1'b1;
                    state_d   = ST_RUN;
                end else begin
                    pc_en       = 1'b0;
                    fd_flush    = 1'b1;
                    drain_cnt_d = drain_cnt_q + DW'(1);
                    if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                        state_d = ST_HALTED;
                    end
                end
            end
            default: begin
                halted = 1'b1;
                freeze = 1'b1;
            end
        endcase

        if (run_rules) begin
            if (mem_busy) begin
                freeze       = 1'b1;
                pend_flush_d = br_taken;
                state_d      = ST_MEM_WAIT;
            end else if (br_eff) begin
                fd_flush  = 1'b1;
                de_flush  = 1'b1;
                flush_inc = 1'b1;
            end else if (load_use) begin
                pc_en    = 1'b0;
                fd_en    = 1'b0;
                de_flush = 1'b1;
            end else if (fd_hlt) begin
                pc_en       = 1'b0;
                fd_flush    = 1'b1;
                drain_cnt_d = '0;
                state_d     = ST_DRAIN;
            end
        end

        if (freeze) begin
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_en    = 1'b0;
            xm_en    = 1'b0;
            mw_en    = 1'b0;
            fd_flush = 1'b0;
            de_flush = 1'b0;
        end

        stall_inc = !pc_en && (state_q != ST_HALTED);

        if (!rst) begin
            pc_en    = 1'b1;
            fd_en    = 1'b1;
            de_en    = 1'b1;
            xm_en    = 1'b1;
            mw_en    = 1'b1;
            fd_flush = 1'b0;
            de_flush = 1'b0;
            halted   = 1'b0;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (flush_inc && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_RUN;
            pend_flush_q <= 1'b0;
            drain_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pend_flush_q <= pend_flush_d;
            drain_cnt_q  <= drain_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed vector bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  fd_rs, fd_rt, de_write_reg;
    logic        fd_uses_rt, fd_hlt, de_mem_read, br_taken, mem_busy;
    logic        pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush, halted;
    logic [15:0] stall_cnt, flush_cnt;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.DRAIN_CYCLES(3), .CNT_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .fd_rs        (fd_rs),
        .fd_rt        (fd_rt),
        .fd_uses_rt   (fd_uses_rt),
        .fd_hlt       (fd_hlt),
        .de_mem_read  (de_mem_read),
        .de_write_reg (de_write_reg),
        .br_taken     (br_taken),
        .mem_busy     (mem_busy),
        .pc_en        (pc_en),
        .fd_en        (fd_en),
        .de_en        (de_en),
        .xm_en        (xm_en),
        .mw_en        (mw_en),
        .fd_flush     (fd_flush),
        .de_flush     (de_flush),
        .halted       (halted),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    // ctl = {pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush}
    localparam logic [6:0] C_IDLE = 7'b1111100;
    localparam logic [6:0] C_LU   = 7'b0011101;
    localparam logic [6:0] C_BR   = 7'b1111111;
    localparam logic [6:0] C_FRZ  = 7'b0000000;
    localparam logic [6:0] C_HLT  = 7'b0111110;

    typedef struct {
        string      name;
        logic [3:0] rs;
        logic [3:0] rt;
        logic       urt;
        logic       hlt;
        logic       mr;
        logic [3:0] wr;
        logic       br;
        logic       mb;
        logic [6:0] ctl;
        int         stall;
        int         flush;
    } vec_t;

    vec_t tbl[11];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] rs, input logic [3:0] rt, input logic urt,
                         input logic hlt, input logic mr, input logic [3:0] wr,
                         input logic br, input logic mb);
        fd_rs        = rs;
        fd_rt        = rt;
        fd_uses_rt   = urt;
        fd_hlt       = hlt;
        de_mem_read  = mr;
        de_write_reg = wr;
        br_taken     = br;
        mem_busy     = mb;
    endtask

    task automatic idle();
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic check_ctl(input string name, input logic [6:0] exp_ctl, input logic exp_halt);
        logic [6:0] act;
        @(negedge clk);
        act = {pc_en, fd_en, de_en, xm_en, mw_en, fd_flush, de_flush};
        n_vec++;
        if (act !== exp_ctl || halted !== exp_halt) begin
            n_bad++;
            $display("FAIL %s: ctl=%b halted=%b, expected ctl=%b halted=%b",
                     name, act, halted, exp_ctl, exp_halt);
        end
    endtask

    task automatic check_cnt(input string name, input int exp_stall, input int exp_flush);
        n_vec++;
        if (int'(stall_cnt) != exp_stall || int'(flush_cnt) != exp_flush) begin
            n_bad++;
            $display("FAIL %s: stall_cnt=%0d flush_cnt=%0d, expected %0d %0d",
                     name, stall_cnt, flush_cnt, exp_stall, exp_flush);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        tbl[0]  = '{"idle",          4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, C_IDLE, 0, 0};
        tbl[1]  = '{"lu_rs",         4'd3, 4'd5, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, C_LU,   1, 0};
        tbl[2]  = '{"lu_r0",         4'd0, 4'd0, 1'b1, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, C_IDLE, 0, 0};
        tbl[3]  = '{"lu_rt",         4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, C_LU,   1, 0};
        tbl[4]  = '{"rt_unused",     4'd2, 4'd5, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, C_IDLE, 0, 0};
        tbl[5]  = '{"no_load",       4'd3, 4'd0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0, C_IDLE, 0, 0};
        tbl[6]  = '{"br_over_lu",    4'd3, 4'd0, 1'b0, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0, C_BR,   0, 1};
        tbl[7]  = '{"mem_busy",      4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, C_FRZ,  1, 0};
        tbl[8]  = '{"hlt",           4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, C_HLT,  1, 0};
        tbl[9]  = '{"lu_over_hlt",   4'd7, 4'd0, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, C_LU,   1, 0};
        tbl[10] = '{"busy_over_br",  4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1, C_FRZ,  1, 0};

        rst = 1'b0;
        idle();
        tick();
        tick();

        // Outputs forced to run values while reset is held, even with mem_busy
        drive(4'd3, 4'd0, 1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1);
        check_ctl("in_reset", C_IDLE, 1'b0);
        tick();
        rst = 1'b1;
        idle();
        check_cnt("reset_cnt", 0, 0);
        check_ctl("reset_idle", C_IDLE, 1'b0);

        for (int i = 0; i < 11; i++) begin
            do_reset();
            drive(tbl[i].rs, tbl[i].rt, tbl[i].urt, tbl[i].hlt,
                  tbl[i].mr, tbl[i].wr, tbl[i].br, tbl[i].mb);
            check_ctl(tbl[i].name, tbl[i].ctl, 1'b0);
            tick();
            idle();
            check_cnt(tbl[i].name, tbl[i].stall, tbl[i].flush);
        end

        // Memory freeze for 4 cycles, branch resolves in cycle 2, squash replayed in cycle 5
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, (c == 2), 1'b1);
            check_ctl("busy_hold", C_FRZ, 1'b0);
            tick();
        end
        idle();
        check_ctl("busy_replay_br", C_BR, 1'b0);
        tick();
        check_cnt("busy_cnt", 4, 1);
        check_ctl("busy_after", C_IDLE, 1'b0);
        tick();

        // HLT drain to halted, then reset recovery
        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        check_ctl("hlt_enter", C_HLT, 1'b0);
        tick();
        idle();
        for (int c = 0; c < 3; c++) begin
            check_ctl("drain", C_HLT, 1'b0);
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            check_ctl("halted", C_FRZ, 1'b1);
            tick();
        end
        check_cnt("halt_cnt", 4, 0);
        rst = 1'b0;
        check_ctl("halt_in_reset", C_IDLE, 1'b0);
        tick();
        rst = 1'b1;
        check_cnt("halt_reset_cnt", 0, 0);
        check_ctl("halt_reset_run", C_IDLE, 1'b0);
        tick();

        // Branch during drain cancels the halt
        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        idle();
        check_ctl("drain1", C_HLT, 1'b0);
        tick();
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0);
        check_ctl("drain_br", C_BR, 1'b0);
        tick();
        idle();
        check_cnt("drain_br_cnt", 2, 1);
        for (int c = 0; c < 5; c++) begin
            check_ctl("no_halt", C_IDLE, 1'b0);
            tick();
        end

        // mem_busy inside drain freezes without advancing the drain count
        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0);
        tick();
        idle();
        check_ctl("dbusy_d0", C_HLT, 1'b0);
        tick();
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        check_ctl("dbusy_frz", C_FRZ, 1'b0);
        tick();
        idle();
        check_ctl("dbusy_d1", C_HLT, 1'b0);
        tick();
        check_ctl("dbusy_d2", C_HLT, 1'b0);
        tick();
        check_ctl("dbusy_halt", C_FRZ, 1'b1);
        check_cnt("dbusy_cnt", 5, 0);
        tick();

        // Reset while a branch squash is pending discards it
        do_reset();
        drive(4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b1);
        tick();
        rst = 1'b0;
        idle();
        tick();
        rst = 1'b1;
        check_ctl("pend_discard", C_IDLE, 1'b0);
        tick();
        check_cnt("pend_discard_cnt", 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
